// File: rtl/dnn_fx_pkg.sv
// Shared fixed-point definitions for the neuron datapath blocks:
// default Q-format, range constants and rounding/overflow mode encodings.
package dnn_fx_pkg;

   localparam int unsigned FX_WIDTH = 32;
   localparam int unsigned FX_FRAC  = 24;

   typedef enum logic {
      RND_FLOOR   = 1'b0,
      RND_HALF_UP = 1'b1
   } rnd_mode_e;

   typedef enum logic {
      OVF_WRAP = 1'b0,
      OVF_SAT  = 1'b1
   } ovf_mode_e;

   // Results are 64 bits wide so any legal WIDTH can slice the low bits.
   function automatic logic [63:0] fx_max(input int unsigned w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] fx_min(input int unsigned w);
      return ~fx_max(w);
   endfunction

   function automatic logic [63:0] fx_one(input int unsigned frac);
      return 64'd1 << frac;
   endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Combinational narrowing of a 2*WIDTH signed product to the WIDTH-bit
// Q-format result, with optional half-up rounding and saturation.
module fx_round_sat
   import dnn_fx_pkg::*;
#(
   parameter int unsigned WIDTH = FX_WIDTH,
   parameter int unsigned FRAC  = FX_FRAC,
   parameter bit          ROUND = 1'b1,
   parameter bit          SAT   = 1'b1
) (
   input  logic [2*WIDTH-1:0] p,
   output logic [WIDTH-1:0]   res,
   output logic               ovf
);

   localparam int unsigned    PW      = 2*WIDTH + 1;
   localparam rnd_mode_e      RMODE   = (ROUND && (FRAC > 0)) ? RND_HALF_UP : RND_FLOOR;
   localparam ovf_mode_e      OMODE   = SAT ? OVF_SAT : OVF_WRAP;
   localparam int unsigned    BIAS_SH = (FRAC > 0) ? FRAC - 1 : 0;
   localparam logic [PW-1:0]  BIAS    = (RMODE == RND_HALF_UP) ? (PW'(1) << BIAS_SH) : '0;
   localparam logic [WIDTH-1:0] RES_MAX = WIDTH'(fx_max(WIDTH));
   localparam logic [WIDTH-1:0] RES_MIN = WIDTH'(fx_min(WIDTH));

   logic signed [PW-1:0] r;
   logic signed [PW-1:0] s;
   logic                 ovf_pos;
   logic                 ovf_neg;

   always_comb begin
      r = $signed({p[2*WIDTH-1], p} + BIAS);
      s = r >>> FRAC;
      // In range only if every bit from WIDTH-1 upward equals the sign bit.
      ovf_pos = ~s[PW-1] & (|s[PW-2:WIDTH-1]);
      ovf_neg =  s[PW-1] & ~(&s[PW-2:WIDTH-1]);
      ovf     = ovf_pos | ovf_neg;
      res     = s[WIDTH-1:0];
      if (OMODE == OVF_SAT) begin
         if (ovf_pos) begin
            res = RES_MAX;
         end else if (ovf_neg) begin
            res = RES_MIN;
         end
      end
   end

endmodule

// File: rtl/mult_fx_pipe.sv
// Two-stage signed fixed-point multiplier with valid/ready handshake;
// a downstream stall freezes both stages.
module mult_fx_pipe
   import dnn_fx_pkg::*;
#(
   parameter int unsigned WIDTH = FX_WIDTH,
   parameter int unsigned FRAC  = FX_FRAC,
   parameter bit          ROUND = 1'b1,
   parameter bit          SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o,
   output logic             o_ovf
);

   logic                 en;
   logic [2*WIDTH-1:0]   prod;
   logic                 s1_valid;
   logic [2*WIDTH-1:0]   s1_p;
   logic [WIDTH-1:0]     rs_res;
   logic                 rs_ovf;

   always_comb begin
      en      = ~o_valid | i_ready;
      o_ready = en;
      // Sign-extend first so min*min lands in the 2*WIDTH product intact.
      prod    = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
   end

   fx_round_sat #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC),
      .ROUND (ROUND),
      .SAT   (SAT)
   ) u_round_sat (
      .p   (s1_p),
      .res (rs_res),
      .ovf (rs_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_p     <= '0;
         o_valid  <= 1'b0;
         o        <= '0;
         o_ovf    <= 1'b0;
      end else if (en) begin
         s1_valid <= i_valid;
         s1_p     <= prod;
         o_valid  <= s1_valid;
         o        <= rs_res;
         o_ovf    <= rs_ovf;
      end
   end

endmodule

// File: doc/mult_fx_pipe.md
Name: mult_fx_pipe

Overview:
- Parametrised, pipelined signed fixed-point multiplier. Successor to the team's combinational 2-input multiplier.
- Adds runtime-free parametric rounding and saturation, an overflow flag, and a valid/ready handshake with backpressure.
- Sits between neuron datapath stages (weight x activation, delta x gradient) so that multiply timing is registered and stallable.

Parameters:
- WIDTH, 32, operand and result width in bits (two's complement); legal 4..64.
- FRAC, 24, fractional bits in operands and result; legal 0..WIDTH-1.
- ROUND, 1, 1 = round half toward +inf before the shift; 0 = truncate (floor).
- SAT, 1, 1 = clamp to the representable range on overflow; 0 = wrap (keep low WIDTH bits).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operand pair on i_a/i_b is valid.
- o_ready  output  1  block accepts an operand pair this cycle.
- i_a  input  WIDTH  signed operand A, Q(WIDTH-FRAC).FRAC.
- i_b  input  WIDTH  signed operand B, same format.
- o_valid  output  1  result on o/o_ovf is valid.
- i_ready  input  1  downstream accepts the result this cycle.
- o  output  WIDTH  signed product, same format as the operands.
- o_ovf  output  1  the exact rounded product was not representable in WIDTH bits.

Behaviour:
- Reset (async assert, sync release): o_valid=0, o=0, o_ovf=0, both stage valids=0, all data registers=0.
- Pipeline is 2 stages. S1 registers the full 2*WIDTH signed product p = i_a*i_b. S2 registers the rounded and saturated result, o_ovf and o_valid.
- Latency: 2 cycles from input accept to o_valid when there is no stall. Throughput: 1 result/cycle.
- Global enable en = !o_valid | i_ready; o_ready = en. Both stages advance only when en=1.
- Input transfer = i_valid & o_ready. Output transfer = o_valid & i_ready.
- Bubbles are not collapsed; a stall freezes the whole pipe. When stalled (o_valid=1, i_ready=0), o, o_ovf and o_valid hold stable, and i_a/i_b are ignored.
- S1 valid loads i_valid & en. A bubble (i_valid=0) propagates as valid=0. Data regs may update freely when their valid is 0.
- Rounding, ROUND=1 and FRAC>0:
  - r = p + 2^(FRAC-1), computed in 2*WIDTH+1 bits.
  - s = r >>> FRAC (arithmetic shift).
  - When ROUND=0 or FRAC=0: s = p >>> FRAC.
- Range check: ovf = (s > 2^(WIDTH-1)-1) | (s < -2^(WIDTH-1)).
- Output selection:
  - SAT=1: o = max (0111..1) when positive ovf, min (1000..0) when negative ovf, else s[WIDTH-1:0].
  - SAT=0: o = s[WIDTH-1:0]; o_ovf is still reported.
- Edge cases:
  - (-2^(WIDTH-1)) * (-2^(WIDTH-1)) is handled without internal overflow.
  - A zero operand gives o=0, ovf=0.
- Reset mid-operation flushes all in-flight data; no result is emitted for operands accepted before reset.
- Simultaneous output transfer and input accept on the same cycle is legal (full throughput).

Decomposition:
- Shared package (dnn_fx_pkg): fixed-point format constants (WIDTH, FRAC defaults), the ONE and MAX/MIN constant functions, and the rounding-mode encodings.
- One natural sub-module: fx_round_sat. It is purely combinational and maps a 2*WIDTH product to the WIDTH result plus ovf, using FRAC/ROUND/SAT. It is reused later by the adder and MAC blocks.
- The pipeline and handshake live in mult_fx_pipe.

Test Plan (WIDTH=32, FRAC=24, i_ready=1 unless stated):
1. Basic: a=0x01800000 (1.5), b=0x02000000 (2.0) -> o=0x03000000 and o_ovf=0, with o_valid exactly 2 cycles after accept. Also a=0xFF000000 (-1.0), b=0x01800000 -> o=0xFE800000.
2. Rounding:
   - a=0x00000001, b=0x00800000: ROUND=1 -> o=0x00000001; ROUND=0 -> o=0x00000000.
   - a=0xFFFFFFFF, b=0x00800000: ROUND=1 -> o=0x00000000; ROUND=0 -> o=0xFFFFFFFF.
3. Saturation:
   - a=b=0x7F000000: SAT=1 -> o=0x7FFFFFFF, o_ovf=1; SAT=0 -> o=0x01000000, o_ovf=1.
   - a=0x7F000000, b=0x81000000: SAT=1 -> o=0x80000000, o_ovf=1.
   - a=b=0x80000000: SAT=1 -> o=0x7FFFFFFF, o_ovf=1.
4. Backpressure:
   - Stream 5 back-to-back products with i_ready held low for cycles 3..6. Expect o/o_valid stable while stalled, o_ready=0 during the stall, and all 5 results delivered in order, none lost or duplicated.
   - A valid/bubble/valid input pattern -> output shows the same pattern shifted by 2 cycles.
5. Reset: assert rst_n=0 asynchronously mid-clock with 2 results in flight -> o_valid=0 and o=0 immediately. After release, the first output is the first post-reset operand pair only.
6. Random: 10k random operands checked against a bit-accurate reference model, under random i_valid/i_ready, for all four ROUND/SAT combinations.
